// File: rtl/tdm_pkg.sv
// Shared types and sizing helpers for the TDM demultiplexer slice.
// TDM_DEMUX8_PARITY_EN adds the PAR state to the state enum.
package tdm_pkg;

    localparam int unsigned NSLOT_DEF = 8;

`ifdef TDM_DEMUX8_PARITY_EN
    typedef enum logic [1:0] {IDLE, RECV, PAR} tdm_state_e;
`else
    typedef enum logic [1:0] {IDLE, RECV} tdm_state_e;
`endif

    // Slot index width; never narrower than one bit.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter: loads 1 on frame start, advances per data beat, wraps to 0 after NSLOT-1.
module tdm_slot_ctr
    import tdm_pkg::*;
#(
    parameter int unsigned NSLOT = NSLOT_DEF,
    localparam int unsigned SW = sel_w(NSLOT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld1,
    input  logic          inc,
    output logic [SW-1:0] cnt,
    output logic          last
);

    assign last = (cnt == SW'(NSLOT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (ld1) begin
            cnt <= SW'(1);
        end else if (inc) begin
            cnt <= last ? '0 : cnt + SW'(1);
        end
    end

endmodule

// File: rtl/tdm_demux8.sv
// Serial TDM to parallel demultiplexer: slot k of each frame lands on q[k].
// Defining TDM_DEMUX8_PARITY_EN appends an even-parity beat checked on perr.
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter int unsigned NSLOT = NSLOT_DEF,
    localparam int unsigned SW = sel_w(NSLOT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             vld,
    input  logic             fs,
    output logic [NSLOT-1:0] q,
    output logic             q_vld,
    output logic [SW-1:0]    sel,
    output logic             busy,
    output logic             err,
    output logic             perr
);

    tdm_state_e       state, state_d;
    logic [NSLOT-1:0] hold, hold_d;
    logic             ctr_ld1, ctr_inc, last;
    logic             q_ld, err_d;

    tdm_slot_ctr #(.NSLOT(NSLOT)) u_ctr (
        .clk (clk),
        .rst (rst),
        .ld1 (ctr_ld1),
        .inc (ctr_inc),
        .cnt (sel),
        .last(last)
    );

    assign busy = (state != IDLE);

`ifdef TDM_DEMUX8_PARITY_EN
    logic perr_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        hold_d  = hold;
        ctr_ld1 = 1'b0;
        ctr_inc = 1'b0;
        q_ld    = 1'b0;
        err_d   = 1'b0;
`ifdef TDM_DEMUX8_PARITY_EN
        perr_d  = 1'b0;
`endif
        if (vld) begin
            case (state)
                IDLE: begin
                    if (fs) begin
                        hold_d    = '0;
                        hold_d[0] = din;
                        ctr_ld1   = 1'b1;
                        state_d   = RECV;
                    end
                end
                RECV: begin
                    if (fs) begin
                        hold_d    = '0;
                        hold_d[0] = din;
                        ctr_ld1   = 1'b1;
                        err_d     = 1'b1;
                    end else begin
                        hold_d[sel] = din;
                        ctr_inc     = 1'b1;
                        if (last) begin
`ifdef TDM_DEMUX8_PARITY_EN
                            state_d = PAR;
`else
                            state_d = IDLE;
                            q_ld    = 1'b1;
`endif
                        end
                    end
                end
`ifdef TDM_DEMUX8_PARITY_EN
                PAR: begin
                    if (fs) begin
                        hold_d    = '0;
                        hold_d[0] = din;
                        ctr_ld1   = 1'b1;
                        err_d     = 1'b1;
                        state_d   = RECV;
                    end else begin
                        // Frame plus parity bit must have an even number of ones.
                        q_ld    = 1'b1;
                        perr_d  = (^hold) ^ din;
                        state_d = IDLE;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold  <= '0;
            q     <= '0;
            q_vld <= 1'b0;
            err   <= 1'b0;
        end else begin
            hold  <= hold_d;
            q_vld <= q_ld;
            err   <= err_d;
            if (q_ld) q <= hold_d;
        end
    end

`ifdef TDM_DEMUX8_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) perr <= 1'b0;
        else     perr <= perr_d;
    end
`else
    assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux8.sv
// Self-checking bench for tdm_demux8: queue-based frame model plus directed literal checks.
// Honours TDM_DEMUX8_PARITY_EN to match the DUT build.
module tb_tdm_demux8;
    localparam int unsigned NSLOT = 8;
`ifdef TDM_DEMUX8_PARITY_EN
    localparam int unsigned PB = 1;
`else
    localparam int unsigned PB = 0;
`endif

    logic                       clk = 1'b0;
    logic                       rst, din, vld, fs;
    logic [NSLOT-1:0]           q;
    logic                       q_vld, busy, err, perr;
    logic [$clog2(NSLOT)-1:0]   sel;

    tdm_demux8 #(.NSLOT(NSLOT)) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .vld  (vld),
        .fs   (fs),
        .q    (q),
        .q_vld(q_vld),
        .sel  (sel),
        .busy (busy),
        .err  (err),
        .perr (perr)
    );

    always #5 clk = ~clk;

    int          n_run = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;
    int unsigned cyc = 0;
    int unsigned n_qv = 0;
    int unsigned n_err = 0;
    int unsigned qv_times[$];

    // Model: bits of the frame in progress, in arrival order.
    bit               mq[$];
    logic [NSLOT-1:0] m_q = '0;
    bit               m_qv = 1'b0, m_err = 1'b0, m_perr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        m_qv   = 1'b0;
        m_err  = 1'b0;
        m_perr = 1'b0;
        if (rst) begin
            mq.delete();
            m_q = '0;
        end else if (vld) begin
            if (fs) begin
                m_err = (mq.size() != 0);
                mq.delete();
                mq.push_back(din);
            end else if (mq.size() != 0) begin
                mq.push_back(din);
                if (mq.size() == NSLOT + PB) begin
                    for (int k = 0; k < NSLOT; k++) m_q[k] = mq[k];
                    m_qv = 1'b1;
`ifdef TDM_DEMUX8_PARITY_EN
                    m_perr = ((^m_q) != mq[NSLOT]);
`endif
                    mq.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("q",     32'(q),     32'(m_q));
            check("q_vld", 32'(q_vld), 32'(m_qv));
            check("sel",   32'(sel),   32'(mq.size() % NSLOT));
            check("busy",  32'(busy),  32'(mq.size() != 0));
            check("err",   32'(err),   32'(m_err));
            check("perr",  32'(perr),  32'(m_perr));
            if (q_vld === 1'b1) begin
                qv_times.push_back(cyc);
                n_qv++;
            end
            if (err === 1'b1) n_err++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            vld = 1'b0;
            din = 1'($urandom);
            fs  = 1'($urandom);
            tick();
        end
    endtask

    task automatic beat(input logic b, input logic f);
        vld = 1'b1;
        din = b;
        fs  = f;
        tick();
        vld = 1'b0;
        din = 1'($urandom);
        fs  = 1'($urandom);
    endtask

    task automatic send_frame(input logic [NSLOT-1:0] value, input int unsigned maxgap, input bit pflip);
        for (int k = 0; k < NSLOT + PB; k++) begin
            if (k < NSLOT) beat(value[k], k == 0);
            else           beat((^value) ^ pflip, 1'b0);
            if (maxgap > 0 && k != NSLOT + PB - 1) idle($urandom_range(maxgap, 1));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int unsigned base_qv, base_err;
        rst = 1'b1;
        vld = 1'b0;
        din = 1'b0;
        fs  = 1'b0;
        tick();
        chk_en = 1'b1;
        check("rst_q", 32'(q), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_qvld", 32'(q_vld), 32'h0);
        rst = 1'b0;

        // Continuous frame.
        send_frame(8'h6F, 0, 1'b0);
        check("cont_qvld", 32'(q_vld), 32'h1);
        check("cont_q", 32'(q), 32'h6F);
        idle(1);
        check("cont_pulse_end", 32'(q_vld), 32'h0);
        check("cont_busy", 32'(busy), 32'h0);

        // Same frame with vld gaps.
        do_reset();
        send_frame(8'h6F, 3, 1'b0);
        check("gap_qvld", 32'(q_vld), 32'h1);
        check("gap_q", 32'(q), 32'h6F);
        idle(2);

        // Back-to-back frames.
        qv_times.delete();
        send_frame(8'hA5, 0, 1'b0);
        check("b2b_q1", 32'(q), 32'hA5);
        send_frame(8'h3C, 0, 1'b0);
        check("b2b_q2", 32'(q), 32'h3C);
        idle(1);
        check("b2b_npulse", 32'(qv_times.size()), 32'd2);
        if (qv_times.size() == 2)
            check("b2b_spacing", 32'(qv_times[1] - qv_times[0]), 32'(NSLOT + PB));

        // Resync mid-frame.
        do_reset();
        base_qv  = n_qv;
        base_err = n_err;
        beat(1'b0, 1'b1);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        check("resync_q_hold", 32'(q), 32'h0);
        send_frame(8'hFF, 0, 1'b0);
        check("resync_q", 32'(q), 32'hFF);
        idle(1);
        check("resync_nerr", 32'(n_err - base_err), 32'd1);
        check("resync_nqv", 32'(n_qv - base_qv), 32'd1);

        // Reset mid-frame.
        do_reset();
        base_qv  = n_qv;
        base_err = n_err;
        beat(1'b1, 1'b1);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        do_reset();
        check("rstmid_q", 32'(q), 32'h0);
        check("rstmid_busy", 32'(busy), 32'h0);
        send_frame(8'h81, 0, 1'b0);
        check("rstmid_q_new", 32'(q), 32'h81);
        idle(1);
        check("rstmid_nqv", 32'(n_qv - base_qv), 32'd1);
        check("rstmid_nerr", 32'(n_err - base_err), 32'd0);

`ifdef TDM_DEMUX8_PARITY_EN
        send_frame(8'h6F, 0, 1'b0);
        check("par_ok_perr", 32'(perr), 32'h0);
        check("par_ok_q", 32'(q), 32'h6F);
        send_frame(8'h6F, 0, 1'b1);
        check("par_bad_perr", 32'(perr), 32'h1);
        check("par_bad_q", 32'(q), 32'h6F);
        idle(1);
`endif

        // Randomised traffic; the model checks every cycle.
        repeat (60) begin
            if ($urandom_range(2) == 0) begin
                send_frame(NSLOT'($urandom), $urandom_range(2), 1'($urandom_range(3) == 0));
            end else begin
                repeat (25) begin
                    rst = ($urandom_range(99) == 0);
                    vld = ($urandom_range(9) < 7);
                    fs  = ($urandom_range(9) == 0);
                    din = 1'($urandom);
                    tick();
                end
                rst = 1'b0;
                vld = 1'b0;
            end
        end

        idle(3);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_demux8.md
TDM_DEMUX8 -- requirements
Module: tdm_demux8

Interface
REQ-001 The block SHALL have parameter NSLOT, default 8, giving the number of data slots per frame (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all flops update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: reset is synchronous and active-high.
REQ-004 The block SHALL have port din, input, 1, the serial TDM data bit for the current slot.
REQ-005 The block SHALL have port vld, input, 1, qualifying din and fs as one beat.
REQ-006 The block SHALL have port fs, input, 1, the frame-start marker: beat carries slot 0.
REQ-007 The block SHALL have port q, output, NSLOT, the last complete demultiplexed frame (slot k -> q[k]).
REQ-008 The block SHALL have port q_vld, output, 1, a one-cycle pulse when q updates.
REQ-009 The block SHALL have port sel, output, $clog2(NSLOT), the slot index expected on the next beat.
REQ-010 The block SHALL have port busy, output, 1, high while a frame is partially received.
REQ-011 The block SHALL have port err, output, 1, a one-cycle pulse on frame resynchronisation.
REQ-012 The block SHALL have port perr, output, 1, a one-cycle parity-error pulse (see Configuration).

Function
REQ-013 The FSM SHALL have states IDLE, RECV and PAR (PAR only with the macro); busy = (state != IDLE).
REQ-014 Beats with vld=0 SHALL be ignored: din and fs are don't-care, and the counter, state and q hold.
REQ-015 IDLE: vld&fs SHALL store din in hold[0], set sel=1 and enter RECV; vld&!fs SHALL be dropped silently.
REQ-016 RECV: vld&!fs SHALL store din in hold[sel] and increment sel.
REQ-017 On the beat with sel=NSLOT-1, the block SHALL load q with the full frame (including that bit) and pulse q_vld on the following cycle, then set sel=0 and go to IDLE (PAR with the macro).
REQ-018 The block SHALL support back-to-back frames with no gap: a fs beat on the cycle right after the last slot starts a new frame.
REQ-019 A vld&fs beat in RECV or PAR (mid-frame) SHALL discard the partial frame, pulse err, and restart at slot 0 with that beat's din; q SHALL be unchanged.
REQ-020 q SHALL hold its value between completed frames; partial frames never appear on q.
REQ-021 Latency SHALL be exactly one clock from sampling the final beat to q/q_vld valid.

Reset
REQ-022 On rst=1 at a clock edge, the block SHALL set state=IDLE, sel=0, hold=0, q=0, q_vld=0, err=0, perr=0; rst SHALL override all other inputs on that edge.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame with no q_vld or err pulse.

Configuration
REQ-024 When macro TDM_DEMUX8_PARITY_EN is defined, the block SHALL, after slot NSLOT-1, enter PAR and treat the next vld&!fs beat as an even-parity bit over the frame.
REQ-025 With the macro defined, q/q_vld SHALL update one cycle after the parity beat, and perr SHALL pulse with q_vld if the parity mismatches; q is still loaded.
REQ-026 Without the macro, the block SHALL have no PAR state, q_vld SHALL follow REQ-017, and perr SHALL be tied 0.

Structure
REQ-027 Package tdm_pkg SHALL hold the default NSLOT, the state enum type, and the slot-index width function/constant.
REQ-028 The slot counter (load 0/1, increment, wrap at NSLOT-1) SHALL be sub-module tdm_slot_ctr; the FSM and hold/q registers SHALL stay in tdm_demux8.

Verification
REQ-029 Reset then send frame 8'b01101111 LSB-first with fs on the first beat, vld=1 continuously -> q=8'h6F, q_vld single pulse one cycle after the 8th beat, busy low afterwards.
REQ-030 The same frame with vld=0 gaps of 1-3 cycles between beats -> identical q=8'h6F; sel advances only on vld beats.
REQ-031 Two back-to-back frames 8'hA5 then 8'h3C with no idle cycles -> q_vld pulses exactly 8 cycles apart, with q=8'hA5 then q=8'h3C.
REQ-032 fs reasserted on the 5th beat of a frame, followed by 7 more beats of 8'hFF -> err pulses once, q goes from 8'h00 to 8'hFF, and no q_vld occurs for the aborted frame.
REQ-033 rst pulsed after the 4th beat, then a full frame 8'h81 -> no pulse for the partial frame, q=8'h81 after the new frame.
REQ-034 With TDM_DEMUX8_PARITY_EN defined, send frame 8'h6F plus parity bit 0 (correct) then 8'h6F plus parity bit 1 -> perr=0 then perr=1, with q=8'h6F both times.
